// File: rtl/fifo_byte_packer.sv
// Packs bytes read from a synchronous FIFO into PACK-lane words with a lane-valid mask.
// A flush emits a partially filled word once any in-flight byte has landed.
module fifo_byte_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       empty,
  output logic                       ren,
  input  logic [DATA_WIDTH-1:0]      rdata,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH*PACK-1:0] m_data,
  output logic [PACK-1:0]            m_keep,
  output logic                       busy
);

  localparam int CW = $clog2(PACK) + 1;
  localparam int WW = DATA_WIDTH * PACK;
  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  localparam logic [CW-1:0] CNT_FULL = CW'(PACK);

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [WW-1:0]   acc_q, acc_d;
  logic            m_valid_q, m_valid_d;
  logic [WW-1:0]   m_data_q, m_data_d;
  logic [PACK-1:0] m_keep_q, m_keep_d;
  logic            busy_q, busy_d;

  logic            ren_s;
  logic            out_free_s;
  logic            emit_s;
  logic [CW-1:0]   cnt_land_s;
  logic [WW-1:0]   acc_land_s;

  function automatic logic [PACK-1:0] keep_mask(input logic [CW-1:0] n);
    logic [PACK:0] m;
    m = ({{PACK{1'b0}}, 1'b1} << n) - {{PACK{1'b0}}, 1'b1};
    return m[PACK-1:0];
  endfunction

  // Read request: only while filling and with room for every outstanding byte.
  always_comb begin
    ren_s = 1'b0;
    if (rst_n && !empty && (state_q == FILL) && ((cnt_q + CW'(pend_q)) < CNT_FULL)) begin
      ren_s = 1'b1;
    end else begin
      ren_s = 1'b0;
    end
  end

  // Accumulator view after this cycle's landing byte; cnt may reach PACK while a full word waits.
  always_comb begin
    acc_land_s = acc_q;
    cnt_land_s = cnt_q;
    if (pend_q) begin
      for (int i = 0; i < PACK; i++) begin
        if (cnt_q == CW'(i)) begin
          acc_land_s[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
        end else begin
          acc_land_s[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      cnt_land_s = cnt_q + CW'(1);
    end else begin
      cnt_land_s = cnt_q;
    end
  end

  // State machine, output-register loading and busy tracking.
  always_comb begin
    out_free_s = !m_valid_q || m_ready;
    emit_s     = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_land_s;
    acc_d      = acc_land_s;
    pend_d     = ren_s;
    m_valid_d  = m_valid_q && !m_ready;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    case (state_q)
      FILL: begin
        if ((cnt_land_s == CNT_FULL) && out_free_s) begin
          emit_s = 1'b1;
        end else begin
          emit_s = 1'b0;
        end
        if (flush && ((cnt_q + CW'(pend_q)) != CW'(0))) begin
          state_d = DRAIN;
        end else begin
          state_d = FILL;
        end
      end
      DRAIN: begin
        if (out_free_s) begin
          emit_s  = (cnt_land_s != CW'(0));
          state_d = FILL;
        end else begin
          emit_s  = 1'b0;
          state_d = DRAIN;
        end
      end
      default: begin
        emit_s  = 1'b0;
        state_d = FILL;
      end
    endcase
    if (emit_s) begin
      m_valid_d = 1'b1;
      m_data_d  = acc_land_s;
      m_keep_d  = keep_mask(cnt_land_s);
      cnt_d     = CW'(0);
      acc_d     = '0;
    end else begin
      cnt_d     = cnt_land_s;
    end
    busy_d = (cnt_d != CW'(0)) || pend_d || m_valid_d || (state_d == DRAIN);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      cnt_q     <= CW'(0);
      pend_q    <= 1'b0;
      acc_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      acc_q     <= acc_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      busy_q    <= busy_d;
    end
  end

  assign ren     = ren_s;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer: a FIFO model feeds bytes, a scoreboard queue
// holds expected words, and a negedge monitor compares every handshake.
module tb_fifo_byte_packer;

  localparam int DW = 8;
  localparam int PK = 4;

  typedef struct packed {
    logic [DW*PK-1:0] d;
    logic [PK-1:0]    k;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             empty = 1'b1;
  logic             ren;
  logic [DW-1:0]    rdata = '0;
  logic             flush = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [DW*PK-1:0] m_data;
  logic [PK-1:0]    m_keep;
  logic             busy;

  logic [DW-1:0]    fq[$];
  exp_t             exp_q[$];
  logic [DW-1:0]    pop_b;
  int               tests = 0;
  int               fails = 0;
  int               reads = 0;
  logic             stall_prev = 1'b0;
  logic [DW*PK-1:0] prev_data = '0;
  logic [PK-1:0]    prev_keep = '0;

  fifo_byte_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .ren(ren), .rdata(rdata),
    .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_keep(m_keep), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sync FIFO model: data appears the cycle after an accepted read.
  always @(posedge clk) begin
    if (ren && !empty) begin
      pop_b = fq.pop_front();
      rdata <= pop_b;
    end
    empty <= (fq.size() == 0);
  end

  // Scoreboard and hold-stability monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ren && !empty) reads++;
      if (stall_prev) begin
        check("stall_valid", {63'd0, m_valid}, 64'd1);
        check("stall_data", {32'd0, m_data}, {32'd0, prev_data});
        check("stall_keep", {60'd0, m_keep}, {60'd0, prev_keep});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {63'd0, m_valid}, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_data", {32'd0, m_data}, {32'd0, e.d});
          check("word_keep", {60'd0, m_keep}, {60'd0, e.k});
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_keep  = m_keep;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [DW*PK-1:0] d, input logic [PK-1:0] k);
    exp_t e;
    e.d = d;
    e.k = k;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check(tag, {63'd0, (exp_q.size() == 0) && !busy}, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ren"}, {63'd0, ren}, 64'd0);
    check({tag, "_mvalid"}, {63'd0, m_valid}, 64'd0);
    check({tag, "_mdata"}, {32'd0, m_data}, 64'd0);
    check({tag, "_mkeep"}, {60'd0, m_keep}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single full word, one ren per byte
    reads = 0;
    fq.push_back(8'h0A); fq.push_back(8'h0B); fq.push_back(8'h0C); fq.push_back(8'h0D);
    expect_word(32'h0D0C0B0A, 4'b1111);
    wait_idle("full_word_done", 40);
    check("full_word_reads", reads, 64'd4);

    // Back-pressure: first word held, second accumulates, reads stop until the register frees
    reads = 0;
    m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) fq.push_back(DW'(i));
    expect_word(32'h04030201, 4'b1111);
    expect_word(32'h08070605, 4'b1111);
    expect_word(32'h00000009, 4'b0001);
    n = 0;
    while (!m_valid && n < 40) begin tick(); n++; end
    check("stall_first_valid", {63'd0, m_valid}, 64'd1);
    repeat (5) tick();
    check("stall_ren_low", {63'd0, ren}, 64'd0);
    check("stall_reads", reads, 64'd8);
    m_ready = 1'b1;
    repeat (6) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("stall_done", 40);
    check("stall_total_reads", reads, 64'd9);

    // Partial word after the FIFO runs dry
    fq.push_back(8'h41); fq.push_back(8'h42);
    expect_word(32'h00004241, 4'b0011);
    repeat (6) tick();
    check("partial_no_output", {63'd0, m_valid}, 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("partial_done", 20);
    check("partial_busy_low", {63'd0, busy}, 64'd0);

    // Flush coinciding with the third read accept
    fq.push_back(8'h41); fq.push_back(8'h42);
    expect_word(32'h00434241, 4'b0111);
    repeat (6) tick();
    fq.push_back(8'h43);
    tick();
    check("inflight_ren", {63'd0, ren && !empty}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("inflight_done", 20);

    // Flush with nothing accumulated is ignored
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("empty_flush_valid", {63'd0, m_valid}, 64'd0);
      check("empty_flush_state", {63'd0, dut.state_q}, 64'd0);
      tick();
    end

    // Reset mid-word discards data; bytes after release start at lane 0
    fq.push_back(8'hEE); fq.push_back(8'hEF);
    repeat (6) tick();
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    fq.push_back(8'h0A); fq.push_back(8'h0B); fq.push_back(8'h0C); fq.push_back(8'h0D);
    repeat (3) tick();
    check_reset_outputs("midreset_hold");
    expect_word(32'h0D0C0B0A, 4'b1111);
    rst_n = 1'b1;
    wait_idle("post_reset_done", 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
